// File: rtl/pc_if.sv
// Program-counter bus: next-PC / redirect requests in, current PC and alignment status out.
interface pc_if;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_curr;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        pc_misaligned;
    logic [31:0] pc_bad_addr;

    modport master (
        output pc_next, pc_en, redirect_valid, redirect_target,
        input  pc_curr, pc_plus4, pc_valid, pc_misaligned, pc_bad_addr
    );

    modport slave (
        input  pc_next, pc_en, redirect_valid, redirect_target,
        output pc_curr, pc_plus4, pc_valid, pc_misaligned, pc_bad_addr
    );
endinterface

// File: rtl/pc.sv
// Program counter with redirect priority, stall and optional alignment rejection.
// Optional feature macro: PC_ALIGN_CHECK_EN (reject loads whose target is not word aligned).
module pc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    pc_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            load_c;
    logic [XLEN-1:0] target_c;

    // Redirect wins over the sequential candidate regardless of pc_en.
    always_comb begin
        load_c   = bus.redirect_valid | bus.pc_en;
        target_c = bus.redirect_valid ? bus.redirect_target : bus.pc_next;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic            reject_c;
    logic            mis_q;
    logic [XLEN-1:0] bad_q;

    always_comb begin
        reject_c = load_c & (target_c[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            valid_q <= 1'b1;
            mis_q   <= reject_c;
            if (reject_c) begin
                bad_q <= target_c;
            end else if (load_c) begin
                pc_q <= target_c;
            end
        end
    end

    assign bus.pc_misaligned = mis_q;
    assign bus.pc_bad_addr   = bad_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (load_c) begin
                pc_q <= target_c;
            end
        end
    end

    assign bus.pc_misaligned = 1'b0;
    assign bus.pc_bad_addr   = '0;
`endif

    assign bus.pc_curr  = pc_q;
    assign bus.pc_valid = valid_q;
    // Wraps modulo 2^32 by truncation.
    assign bus.pc_plus4 = pc_q + XLEN'(4);
endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: reset, sequencing, stall, redirect, wrap, alignment and async reset.
module tb_pc;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pc_if bus_i ();

    pc #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rt, input logic en, input logic [31:0] nx);
        bus_i.redirect_valid  = rv;
        bus_i.redirect_target = rt;
        bus_i.pc_en           = en;
        bus_i.pc_next         = nx;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("reset_pc_curr",   bus_i.pc_curr, 32'h0);
        chk("reset_pc_valid",  32'(bus_i.pc_valid), 32'h0);
        chk("reset_misalign",  32'(bus_i.pc_misaligned), 32'h0);
        chk("reset_bad_addr",  bus_i.pc_bad_addr, 32'h0);
        repeat (3) tick();
        chk("reset_hold_pc",   bus_i.pc_curr, 32'h0);
        chk("reset_hold_valid", 32'(bus_i.pc_valid), 32'h0);

        // Release reset and step sequentially.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h4);
        #1;
        chk("seq0_pc",       bus_i.pc_curr, 32'h0);
        chk("seq0_plus4",    bus_i.pc_plus4, 32'h4);
        chk("seq0_valid",    32'(bus_i.pc_valid), 32'h0);
        tick();
        chk("seq1_pc",       bus_i.pc_curr, 32'h4);
        chk("seq1_valid",    32'(bus_i.pc_valid), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 32'h8);
        tick();
        chk("seq2_pc",       bus_i.pc_curr, 32'h8);

        // Stall for two cycles at 8.
        drive(1'b0, 32'h0, 1'b0, 32'hC);
        tick();
        chk("stall1_pc",     bus_i.pc_curr, 32'h8);
        tick();
        chk("stall2_pc",     bus_i.pc_curr, 32'h8);
        chk("stall2_plus4",  bus_i.pc_plus4, 32'hC);
        drive(1'b0, 32'h0, 1'b1, 32'hC);
        tick();
        chk("seq3_pc",       bus_i.pc_curr, 32'hC);

        // Redirect beats pc_en / pc_next.
        drive(1'b1, 32'h100, 1'b1, 32'h20);
        tick();
        chk("redir_pc",      bus_i.pc_curr, 32'h100);
        chk("redir_mis",     32'(bus_i.pc_misaligned), 32'h0);
        drive(1'b1, 32'h200, 1'b0, 32'h20);
        tick();
        chk("redir_noen_pc", bus_i.pc_curr, 32'h200);

        // Wrap at the top of the address space.
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        chk("wrap_pc",       bus_i.pc_curr, 32'hFFFF_FFFC);
        chk("wrap_plus4",    bus_i.pc_plus4, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        chk("wrap_next_pc",  bus_i.pc_curr, 32'h0);

        // Misaligned redirect.
        drive(1'b1, 32'h102, 1'b0, 32'h0);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc",        bus_i.pc_curr, 32'h0);
        chk("mis_flag",      32'(bus_i.pc_misaligned), 32'h1);
        chk("mis_bad",       bus_i.pc_bad_addr, 32'h102);
`else
        chk("mis_pc",        bus_i.pc_curr, 32'h102);
        chk("mis_flag",      32'(bus_i.pc_misaligned), 32'h0);
        chk("mis_bad",       bus_i.pc_bad_addr, 32'h0);
`endif
        drive(1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        chk("mis_after_pc",   bus_i.pc_curr, 32'h100);
        chk("mis_after_flag", 32'(bus_i.pc_misaligned), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_after_bad",  bus_i.pc_bad_addr, 32'h102);
`else
        chk("mis_after_bad",  bus_i.pc_bad_addr, 32'h0);
`endif

        // Async reset mid-cycle with a redirect pending.
        drive(1'b1, 32'h300, 1'b1, 32'h104);
        #3;
        rst = 1'b0;
        #1;
        chk("async_pc",      bus_i.pc_curr, 32'h0);
        chk("async_valid",   32'(bus_i.pc_valid), 32'h0);
        chk("async_bad",     bus_i.pc_bad_addr, 32'h0);
        tick();
        chk("async_hold_pc", bus_i.pc_curr, 32'h0);

        // First edge after release performs a normal redirect load.
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        chk("post_rst_pc",    bus_i.pc_curr, 32'h40);
        chk("post_rst_valid", 32'(bus_i.pc_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
